// File: rtl/ctl_reg_fetch_pkg.sv
// Shared types, reset defaults and register-map constants for the controller
// register fetch sequencer.
package ctl_reg_fetch_pkg;

  localparam logic [7:0] ADDR_CTL_FLAG   = 8'h00;
  localparam logic [7:0] ADDR_FPGA_STATE = 8'h01;
  localparam int         FORCE_FAN_BIT   = 13;
  localparam int         NUM_GROUPS      = 6;
  localparam int         SHADOW_WORDS    = 14;

  typedef enum logic [2:0] {
    IDLE, FLAG_RD, DECIDE, LOAD, COMMIT, STATE_WR
  } state_e;

  // Order doubles as service priority and as the ctl flag bit index.
  typedef enum logic [2:0] {
    GRP_MOD      = 3'd0,
    GRP_STM      = 3'd1,
    GRP_SILENCER = 3'd2,
    GRP_PWE      = 3'd3,
    GRP_DEBUG    = 3'd4,
    GRP_SYNC     = 3'd5
  } group_e;

  typedef enum logic {STM_FOCUS = 1'b0, STM_GAIN = 1'b1} stm_mode_e;
  typedef enum logic {FIXED_COMPLETION_STEPS = 1'b0, FIXED_UPDATE_RATE = 1'b1} silencer_mode_e;

  typedef struct packed {
    logic        req_rd_segment;
    logic [15:0] cycle_0;
    logic [15:0] cycle_1;
    logic [31:0] freq_div_0;
    logic [31:0] freq_div_1;
    logic [15:0] rep_0;
    logic [15:0] rep_1;
    logic [15:0] transition_mode;
  } mod_settings_t;

  typedef struct packed {
    stm_mode_e   mode;
    logic        req_rd_segment;
    logic [15:0] cycle_0;
    logic [15:0] cycle_1;
    logic [31:0] freq_div_0;
    logic [31:0] freq_div_1;
    logic [15:0] rep_0;
    logic [15:0] rep_1;
    logic [15:0] sound_speed_0;
    logic [15:0] sound_speed_1;
    logic [15:0] transition_value;
  } stm_settings_t;

  typedef struct packed {
    silencer_mode_e mode;
    logic [15:0]    update_rate_intensity;
    logic [15:0]    update_rate_phase;
    logic [15:0]    completion_steps_intensity;
    logic [15:0]    completion_steps_phase;
  } silencer_settings_t;

  typedef logic [SHADOW_WORDS-1:0][15:0] shadow_t;

  localparam mod_settings_t MOD_DEFAULT = '{
    req_rd_segment: 1'b0, cycle_0: 16'd0, cycle_1: 16'd0,
    freq_div_0: 32'd10, freq_div_1: 32'd10,
    rep_0: 16'hFFFF, rep_1: 16'hFFFF, transition_mode: 16'd0};

  localparam stm_settings_t STM_DEFAULT = '{
    mode: STM_FOCUS, req_rd_segment: 1'b0, cycle_0: 16'd0, cycle_1: 16'd0,
    freq_div_0: 32'd10, freq_div_1: 32'd10,
    rep_0: 16'hFFFF, rep_1: 16'hFFFF,
    sound_speed_0: 16'd0, sound_speed_1: 16'd0, transition_value: 16'd0};

  localparam silencer_settings_t SILENCER_DEFAULT = '{
    mode: FIXED_COMPLETION_STEPS,
    update_rate_intensity: 16'd256, update_rate_phase: 16'd256,
    completion_steps_intensity: 16'd10, completion_steps_phase: 16'd40};

  function automatic logic [7:0] group_base(group_e g);
    case (g)
      GRP_MOD:      return 8'h20;
      GRP_STM:      return 8'h50;
      GRP_SILENCER: return 8'h40;
      GRP_PWE:      return 8'h61;
      GRP_DEBUG:    return 8'hF0;
      default:      return 8'h11;
    endcase
  endfunction

  function automatic logic [3:0] group_len(group_e g);
    case (g)
      GRP_MOD:      return 4'd10;
      GRP_STM:      return 4'd14;
      GRP_SILENCER: return 4'd5;
      GRP_PWE:      return 4'd1;
      GRP_DEBUG:    return 4'd1;
      default:      return 4'd4;
    endcase
  endfunction

  // Lowest set bit wins; only meaningful when p is non-zero.
  function automatic group_e first_pending(logic [NUM_GROUPS-1:0] p);
    group_e g;
    g = GRP_SYNC;
    for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
      if (p[i]) g = group_e'(i[2:0]);
    end
    return g;
  endfunction

  function automatic mod_settings_t unpack_mod(shadow_t s);
    mod_settings_t m;
    m.req_rd_segment  = s[0][0];
    m.cycle_0         = s[1];
    m.cycle_1         = s[2];
    m.freq_div_0      = {s[4], s[3]};
    m.freq_div_1      = {s[6], s[5]};
    m.rep_0           = s[7];
    m.rep_1           = s[8];
    m.transition_mode = s[9];
    return m;
  endfunction

  // Word 2 is the STM memory write page; it belongs to the host side only.
  function automatic stm_settings_t unpack_stm(shadow_t s);
    stm_settings_t m;
    m.mode             = stm_mode_e'(s[0][0]);
    m.req_rd_segment   = s[1][0];
    m.cycle_0          = s[3];
    m.cycle_1          = s[4];
    m.freq_div_0       = {s[6], s[5]};
    m.freq_div_1       = {s[8], s[7]};
    m.rep_0            = s[9];
    m.rep_1            = s[10];
    m.sound_speed_0    = s[11];
    m.sound_speed_1    = s[12];
    m.transition_value = s[13];
    return m;
  endfunction

  function automatic silencer_settings_t unpack_silencer(shadow_t s);
    silencer_settings_t m;
    m.mode                       = silencer_mode_e'(s[0][0]);
    m.update_rate_intensity      = s[1];
    m.update_rate_phase          = s[2];
    m.completion_steps_intensity = s[3];
    m.completion_steps_phase     = s[4];
    return m;
  endfunction

endpackage

// File: rtl/ctl_reg_fetch_reader.sv
// Issues a run of consecutive BRAM addresses and tags each returning word
// with its offset once the read latency has elapsed.
module bram_burst_reader #(
  parameter int RD_LATENCY = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [7:0] base,
  input  logic [3:0] len,
  output logic [7:0] addr,
  output logic       issue,
  output logic [3:0] rd_idx,
  output logic       rd_valid,
  output logic       done
);

  logic [7:0]            addr_q;
  logic [3:0]            remain_q;
  logic [3:0]            issue_idx_q;
  logic [3:0]            last_idx_q;
  logic [RD_LATENCY-1:0] vpipe_q;
  logic [3:0]            idx_pipe_q [RD_LATENCY];

  assign issue    = (remain_q != 4'd0);
  assign addr     = addr_q;
  assign rd_valid = vpipe_q[RD_LATENCY-1];
  assign rd_idx   = idx_pipe_q[RD_LATENCY-1];
  assign done     = rd_valid && (rd_idx == last_idx_q);

  // Address generator: remaining-word down-counter, one issue per cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q      <= '0;
      remain_q    <= '0;
      issue_idx_q <= '0;
      last_idx_q  <= '0;
    end else if (start) begin
      addr_q      <= base;
      remain_q    <= len;
      issue_idx_q <= '0;
      last_idx_q  <= len - 4'd1;
    end else if (issue) begin
      addr_q      <= addr_q + 8'd1;
      remain_q    <= remain_q - 4'd1;
      issue_idx_q <= issue_idx_q + 4'd1;
    end
  end

  // Delay line matching the BRAM read latency for valid and word offset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vpipe_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) idx_pipe_q[i] <= '0;
    end else begin
      vpipe_q[0]    <= issue;
      idx_pipe_q[0] <= issue_idx_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe_q[i]    <= vpipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
    end
  end

endmodule

// File: rtl/ctl_reg_fetch.sv
// Polls the controller-BRAM ctl flag word, reloads register groups on flag
// rising edges and commits them atomically; mirrors THERMO into FPGA_STATE.
//
// state    | meaning
// IDLE     | present the ctl flag address
// FLAG_RD  | wait out read latency, capture flags, queue rising edges
// DECIDE   | state write first, then lowest pending group, else poll again
// LOAD     | burst-read the selected group into the shadow
// COMMIT   | shadow -> settings output, strobe, clear pending bit
// STATE_WR | write THERMO to FPGA_STATE
module ctl_reg_fetch
  import ctl_reg_fetch_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic [7:0]         BRAM_ADDR,
  input  logic [15:0]        BRAM_RD_DATA,
  output logic               BRAM_WE,
  output logic [15:0]        BRAM_WR_DATA,
  input  logic               THERMO,
  output logic               FORCE_FAN,
  output mod_settings_t      MOD_SETTINGS,
  output stm_settings_t      STM_SETTINGS,
  output silencer_settings_t SILENCER_SETTINGS,
  output logic [15:0]        PWE_FULL_WIDTH_START,
  output logic [7:0]         DEBUG_OUT_IDX,
  output logic [63:0]        ECAT_SYNC_TIME,
  output logic               MOD_UPDATE,
  output logic               STM_UPDATE,
  output logic               SILENCER_UPDATE,
  output logic               PWE_UPDATE,
  output logic               DEBUG_UPDATE,
  output logic               SYNC_UPDATE,
  output logic               BUSY
);

  state_e                 state_q, state_d;
  group_e                 sel_q, pick;
  logic [1:0]             wait_cnt_q;
  logic [NUM_GROUPS-1:0]  pending_q;
  logic [NUM_GROUPS-1:0]  prev_flag_q;
  logic                   thermo_last_q;
  shadow_t                shadow_q;

  logic                   burst_start;
  logic [7:0]             burst_addr;
  logic                   burst_issue;
  logic [3:0]             burst_idx;
  logic                   burst_valid;
  logic                   burst_done;

  assign pick = first_pending(pending_q);
  assign BUSY = (state_q != IDLE);

  bram_burst_reader #(.RD_LATENCY(RD_LATENCY)) u_reader (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (burst_start),
    .base     (group_base(pick)),
    .len      (group_len(pick)),
    .addr     (burst_addr),
    .issue    (burst_issue),
    .rd_idx   (burst_idx),
    .rd_valid (burst_valid),
    .done     (burst_done)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and BRAM port drive.
  always_comb begin
    state_d      = state_q;
    burst_start  = 1'b0;
    BRAM_ADDR    = '0;
    BRAM_WE      = 1'b0;
    BRAM_WR_DATA = '0;
    case (state_q)
      IDLE: begin
        BRAM_ADDR = ADDR_CTL_FLAG;
        state_d   = FLAG_RD;
      end
      FLAG_RD: begin
        BRAM_ADDR = ADDR_CTL_FLAG;
        if (wait_cnt_q == 2'd0) state_d = DECIDE;
      end
      DECIDE: begin
        if (THERMO != thermo_last_q) begin
          state_d = STATE_WR;
        end else if (pending_q != '0) begin
          state_d     = LOAD;
          burst_start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (burst_issue) BRAM_ADDR = burst_addr;
        if (burst_done)  state_d   = COMMIT;
      end
      COMMIT: state_d = DECIDE;
      STATE_WR: begin
        BRAM_WE      = 1'b1;
        BRAM_ADDR    = ADDR_FPGA_STATE;
        BRAM_WR_DATA = {15'b0, THERMO};
        state_d      = DECIDE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag capture, edge queueing, group selection and thermo tracking.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt_q    <= '0;
      pending_q     <= '0;
      prev_flag_q   <= '0;
      thermo_last_q <= 1'b0;
      FORCE_FAN     <= 1'b0;
      sel_q         <= GRP_MOD;
    end else begin
      case (state_q)
        IDLE: wait_cnt_q <= 2'(RD_LATENCY - 1);
        FLAG_RD: begin
          if (wait_cnt_q == 2'd0) begin
            FORCE_FAN   <= BRAM_RD_DATA[FORCE_FAN_BIT];
            pending_q   <= pending_q | (BRAM_RD_DATA[NUM_GROUPS-1:0] & ~prev_flag_q);
            prev_flag_q <= BRAM_RD_DATA[NUM_GROUPS-1:0];
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end
        DECIDE:   if (burst_start) sel_q <= pick;
        COMMIT:   pending_q[sel_q] <= 1'b0;
        STATE_WR: thermo_last_q <= THERMO;
        default: ;
      endcase
    end
  end

  // Shadow capture of burst words; invisible until COMMIT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) shadow_q <= '0;
    else if (burst_valid) shadow_q[burst_idx] <= BRAM_RD_DATA;
  end

  // Atomic commit: settings and strobe change together on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MOD_SETTINGS         <= MOD_DEFAULT;
      STM_SETTINGS         <= STM_DEFAULT;
      SILENCER_SETTINGS    <= SILENCER_DEFAULT;
      PWE_FULL_WIDTH_START <= '0;
      DEBUG_OUT_IDX        <= '0;
      ECAT_SYNC_TIME       <= '0;
      MOD_UPDATE           <= 1'b0;
      STM_UPDATE           <= 1'b0;
      SILENCER_UPDATE      <= 1'b0;
      PWE_UPDATE           <= 1'b0;
      DEBUG_UPDATE         <= 1'b0;
      SYNC_UPDATE          <= 1'b0;
    end else begin
      MOD_UPDATE      <= 1'b0;
      STM_UPDATE      <= 1'b0;
      SILENCER_UPDATE <= 1'b0;
      PWE_UPDATE      <= 1'b0;
      DEBUG_UPDATE    <= 1'b0;
      SYNC_UPDATE     <= 1'b0;
      if (state_q == COMMIT) begin
        case (sel_q)
          GRP_MOD: begin
            MOD_SETTINGS <= unpack_mod(shadow_q);
            MOD_UPDATE   <= 1'b1;
          end
          GRP_STM: begin
            STM_SETTINGS <= unpack_stm(shadow_q);
            STM_UPDATE   <= 1'b1;
          end
          GRP_SILENCER: begin
            SILENCER_SETTINGS <= unpack_silencer(shadow_q);
            SILENCER_UPDATE   <= 1'b1;
          end
          GRP_PWE: begin
            PWE_FULL_WIDTH_START <= shadow_q[0];
            PWE_UPDATE           <= 1'b1;
          end
          GRP_DEBUG: begin
            DEBUG_OUT_IDX <= shadow_q[0][7:0];
            DEBUG_UPDATE  <= 1'b1;
          end
          default: begin
            ECAT_SYNC_TIME <= {shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
            SYNC_UPDATE    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctl_reg_fetch.sv
// Self-checking bench: BRAM model, strobe/write observers and a scoreboard of
// expected settings commits.
module tb_ctl_reg_fetch;
  import ctl_reg_fetch_pkg::*;

  localparam int RDL = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         bram_addr;
  logic [15:0]        bram_rd_data;
  logic               bram_we;
  logic [15:0]        bram_wr_data;
  logic               thermo = 1'b0;
  logic               force_fan;
  mod_settings_t      mod_s;
  stm_settings_t      stm_s;
  silencer_settings_t sil_s;
  logic [15:0]        pwe;
  logic [7:0]         dbg;
  logic [63:0]        sync_time;
  logic               mod_up, stm_up, sil_up, pwe_up, dbg_up, sync_up;
  logic               busy;

  typedef struct {
    int           grp;
    logic [255:0] val;
    int           nstrobe;
    longint       cyc;
  } obs_t;

  typedef struct {
    int           grp;
    logic [255:0] val;
  } exp_t;

  logic [15:0] mem [256];
  logic [15:0] rd_pipe [RDL];
  obs_t        obs_q [$];
  exp_t        exp_q [$];
  logic [23:0] wr_q [$];
  longint      cyc = 0;
  int          busy_hi = 0, busy_lo = 0, atomic_bad = 0;
  int          errors = 0, checks = 0, obs_rd = 0;

  mod_settings_t      def_mod, prev_mod;
  stm_settings_t      def_stm, prev_stm;
  silencer_settings_t def_sil, prev_sil;
  logic [15:0]        prev_pwe;
  logic [7:0]         prev_dbg;
  logic [63:0]        prev_sync;
  logic               prev_rst = 1'b0;

  ctl_reg_fetch #(.RD_LATENCY(RDL)) dut (
    .CLK(clk), .RST_N(rst_n),
    .BRAM_ADDR(bram_addr), .BRAM_RD_DATA(bram_rd_data),
    .BRAM_WE(bram_we), .BRAM_WR_DATA(bram_wr_data),
    .THERMO(thermo), .FORCE_FAN(force_fan),
    .MOD_SETTINGS(mod_s), .STM_SETTINGS(stm_s), .SILENCER_SETTINGS(sil_s),
    .PWE_FULL_WIDTH_START(pwe), .DEBUG_OUT_IDX(dbg), .ECAT_SYNC_TIME(sync_time),
    .MOD_UPDATE(mod_up), .STM_UPDATE(stm_up), .SILENCER_UPDATE(sil_up),
    .PWE_UPDATE(pwe_up), .DEBUG_UPDATE(dbg_up), .SYNC_UPDATE(sync_up),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read with RDL cycles from address to data.
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bram_addr];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rd_data = rd_pipe[RDL-1];

  // Observer: records strobes with the settings visible in that cycle, writes,
  // BUSY activity and any settings change not accompanied by its strobe.
  always @(negedge clk) begin
    obs_t o;
    int   n;
    n = int'(mod_up) + int'(stm_up) + int'(sil_up) + int'(pwe_up) + int'(dbg_up) + int'(sync_up);
    o.nstrobe = n;
    o.cyc = cyc;
    if (mod_up)  begin o.grp = 0; o.val = '0; o.val[$bits(mod_settings_t)-1:0] = mod_s; obs_q.push_back(o); end
    if (stm_up)  begin o.grp = 1; o.val = '0; o.val[$bits(stm_settings_t)-1:0] = stm_s; obs_q.push_back(o); end
    if (sil_up)  begin o.grp = 2; o.val = '0; o.val[$bits(silencer_settings_t)-1:0] = sil_s; obs_q.push_back(o); end
    if (pwe_up)  begin o.grp = 3; o.val = '0; o.val[15:0] = pwe; obs_q.push_back(o); end
    if (dbg_up)  begin o.grp = 4; o.val = '0; o.val[7:0] = dbg; obs_q.push_back(o); end
    if (sync_up) begin o.grp = 5; o.val = '0; o.val[63:0] = sync_time; obs_q.push_back(o); end
    if (bram_we) wr_q.push_back({bram_addr, bram_wr_data});
    if (busy === 1'b1) busy_hi++;
    if (busy === 1'b0) busy_lo++;
    if (rst_n && prev_rst) begin
      if (mod_s !== prev_mod && !mod_up) atomic_bad++;
      if (stm_s !== prev_stm && !stm_up) atomic_bad++;
      if (sil_s !== prev_sil && !sil_up) atomic_bad++;
      if (pwe !== prev_pwe && !pwe_up) atomic_bad++;
      if (dbg !== prev_dbg && !dbg_up) atomic_bad++;
      if (sync_time !== prev_sync && !sync_up) atomic_bad++;
    end
    prev_mod = mod_s; prev_stm = stm_s; prev_sil = sil_s;
    prev_pwe = pwe; prev_dbg = dbg; prev_sync = sync_time;
    prev_rst = rst_n;
  end

  function automatic mod_settings_t exp_mod();
    mod_settings_t m;
    m.req_rd_segment  = mem[8'h20][0];
    m.cycle_0         = mem[8'h21];
    m.cycle_1         = mem[8'h22];
    m.freq_div_0      = {mem[8'h24], mem[8'h23]};
    m.freq_div_1      = {mem[8'h26], mem[8'h25]};
    m.rep_0           = mem[8'h27];
    m.rep_1           = mem[8'h28];
    m.transition_mode = mem[8'h29];
    return m;
  endfunction

  function automatic stm_settings_t exp_stm();
    stm_settings_t m;
    m.mode             = stm_mode_e'(mem[8'h50][0]);
    m.req_rd_segment   = mem[8'h51][0];
    m.cycle_0          = mem[8'h53];
    m.cycle_1          = mem[8'h54];
    m.freq_div_0       = {mem[8'h56], mem[8'h55]};
    m.freq_div_1       = {mem[8'h58], mem[8'h57]};
    m.rep_0            = mem[8'h59];
    m.rep_1            = mem[8'h5A];
    m.sound_speed_0    = mem[8'h5B];
    m.sound_speed_1    = mem[8'h5C];
    m.transition_value = mem[8'h5D];
    return m;
  endfunction

  function automatic silencer_settings_t exp_sil();
    silencer_settings_t m;
    m.mode                       = silencer_mode_e'(mem[8'h40][0]);
    m.update_rate_intensity      = mem[8'h41];
    m.update_rate_phase          = mem[8'h42];
    m.completion_steps_intensity = mem[8'h43];
    m.completion_steps_phase     = mem[8'h44];
    return m;
  endfunction

  task automatic push_exp(input int grp);
    exp_t e;
    e.grp = grp;
    e.val = '0;
    case (grp)
      0: e.val[$bits(mod_settings_t)-1:0] = exp_mod();
      1: e.val[$bits(stm_settings_t)-1:0] = exp_stm();
      2: e.val[$bits(silencer_settings_t)-1:0] = exp_sil();
      3: e.val[15:0] = mem[8'h61];
      4: e.val[7:0] = mem[8'hF0][7:0];
      default: e.val[63:0] = {mem[8'h14], mem[8'h13], mem[8'h12], mem[8'h11]};
    endcase
    exp_q.push_back(e);
  endtask

  task automatic wait_events(input int n0, input int want, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n0 + want; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    thermo = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bram_addr !== 8'h00 || bram_we !== 1'b0 || bram_wr_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bram: addr=%h we=%b wd=%h, expected 00/0/0000", bram_addr, bram_we, bram_wr_data);
    end
    checks++;
    if (force_fan !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fan_busy: fan=%b busy=%b, expected 0/0", force_fan, busy);
    end
    checks++;
    if ({mod_up, stm_up, sil_up, pwe_up, dbg_up, sync_up} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, expected 000000", {mod_up, stm_up, sil_up, pwe_up, dbg_up, sync_up});
    end
    checks++;
    if (mod_s !== def_mod) begin
      errors++;
      $display("FAIL reset_mod: got %h, expected %h", mod_s, def_mod);
    end
    checks++;
    if (stm_s !== def_stm) begin
      errors++;
      $display("FAIL reset_stm: got %h, expected %h", stm_s, def_stm);
    end
    checks++;
    if (sil_s !== def_sil || sil_s.completion_steps_intensity !== 16'd10 || sil_s.completion_steps_phase !== 16'd40) begin
      errors++;
      $display("FAIL reset_silencer: got %h, expected %h", sil_s, def_sil);
    end
    checks++;
    if (pwe !== 16'h0 || dbg !== 8'h0 || sync_time !== 64'h0) begin
      errors++;
      $display("FAIL reset_misc: pwe=%h dbg=%h sync=%h, expected zeros", pwe, dbg, sync_time);
    end
    rst_n = 1'b1;
    busy_hi = 0;
    busy_lo = 0;
    repeat (80) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: strobes=%0d writes=%0d, expected 0/0", obs_q.size(), wr_q.size());
    end
    checks++;
    if (busy_hi < 10 || busy_lo < 10) begin
      errors++;
      $display("FAIL busy_toggle: high=%0d low=%0d samples, expected both >=10", busy_hi, busy_lo);
    end
    checks++;
    if (mod_s !== def_mod || stm_s !== def_stm || sil_s !== def_sil) begin
      errors++;
      $display("FAIL idle_defaults: settings moved without an edge");
    end
  endtask

  task automatic test_mod_edge();
    int   n0;
    obs_t o;
    exp_t e;
    mod_settings_t m;
    mem[8'h23] = 16'h5678;
    mem[8'h24] = 16'h0012;
    push_exp(0);
    n0 = obs_q.size();
    mem[8'h00] = 16'h0001;
    wait_events(n0, 1, 300);
    repeat (150) @(negedge clk);
    checks++;
    if (obs_q.size() - n0 != 1) begin
      errors++;
      $display("FAIL mod_single_strobe: got %0d strobes, expected 1", obs_q.size() - n0);
    end
    if (obs_q.size() > n0) begin
      o = obs_q[obs_rd];
      e = exp_q.pop_front();
      m = mod_settings_t'(o.val[$bits(mod_settings_t)-1:0]);
      checks++;
      if (o.grp != 0 || o.val !== e.val) begin
        errors++;
        $display("FAIL mod_value: grp=%0d val=%h, expected grp=0 val=%h", o.grp, o.val, e.val);
      end
      checks++;
      if (m.freq_div_0 !== 32'h00125678) begin
        errors++;
        $display("FAIL mod_freq_div_0: got %h at strobe, expected 00125678", m.freq_div_0);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_group_burst(input string name, input logic [15:0] flag, input int g0);
    int     n0;
    obs_t   o;
    exp_t   e;
    longint last_cyc;
    mem[8'h00] = 16'h0000;
    repeat (40) @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      if (a >= 8'h02) mem[a] = 16'($urandom_range(0, 65535));
    end
    for (int k = 0; k < 3; k++) push_exp(g0 + k);
    n0 = obs_q.size();
    mem[8'h00] = flag;
    wait_events(n0, 3, 500);
    repeat (60) @(negedge clk);
    checks++;
    if (obs_q.size() - n0 != 3) begin
      errors++;
      $display("FAIL %s_count: got %0d strobes, expected 3", name, obs_q.size() - n0);
    end
    last_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        o = obs_q[obs_rd];
        obs_rd++;
        checks++;
        if (o.grp != e.grp || o.val !== e.val || o.nstrobe != 1 || o.cyc <= last_cyc) begin
          errors++;
          $display("FAIL %s_commit%0d: grp=%0d n=%0d cyc=%0d val=%h, expected grp=%0d n=1 val=%h",
                   name, k, o.grp, o.nstrobe, o.cyc, o.val, e.grp, e.val);
        end
        last_cyc = o.cyc;
      end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_reset_mid_load();
    int   n0, i;
    obs_t o;
    exp_t e;
    mem[8'h00] = 16'h0000;
    repeat (40) @(negedge clk);
    for (int a = 8'h50; a <= 8'h5D; a++) mem[a] = 16'($urandom_range(1, 65535));
    mem[8'h00] = 16'h0002;
    for (i = 0; i < 300 && bram_addr !== 8'h50; i++) @(negedge clk);
    checks++;
    if (bram_addr !== 8'h50) begin
      errors++;
      $display("FAIL stm_load_start: addr=%h, expected 50 within 300 cycles", bram_addr);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    mem[8'h00] = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (stm_s !== def_stm || mod_s !== def_mod || sil_s !== def_sil) begin
      errors++;
      $display("FAIL midload_reset_values: stm=%h, expected %h", stm_s, def_stm);
    end
    rst_n = 1'b1;
    n0 = obs_q.size();
    repeat (120) @(negedge clk);
    checks++;
    if (obs_q.size() != n0 || stm_s !== def_stm) begin
      errors++;
      $display("FAIL midload_no_replay: strobes=%0d stm=%h, expected 0 and defaults", obs_q.size() - n0, stm_s);
    end
    obs_rd = obs_q.size();
    push_exp(1);
    mem[8'h00] = 16'h0002;
    wait_events(n0, 1, 300);
    checks++;
    if (obs_rd < obs_q.size()) begin
      o = obs_q[obs_rd];
      e = exp_q.pop_front();
      if (o.grp != 1 || o.val !== e.val) begin
        errors++;
        $display("FAIL midload_new_edge: grp=%0d val=%h, expected grp=1 val=%h", o.grp, o.val, e.val);
      end
    end else begin
      void'(exp_q.pop_front());
      errors++;
      $display("FAIL midload_new_edge: no STM strobe, expected 1");
    end
    repeat (30) @(negedge clk);
    obs_rd = obs_q.size();
  endtask

  task automatic test_thermo();
    int n0;
    n0 = wr_q.size();
    thermo = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (wr_q.size() - n0 != 1 || wr_q[n0] !== {8'h01, 16'h0001}) begin
      errors++;
      $display("FAIL thermo_rise: writes=%0d first=%h, expected 1 write of 01/0001", wr_q.size() - n0,
               (wr_q.size() > n0) ? wr_q[n0] : 24'h0);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (wr_q.size() - n0 != 1) begin
      errors++;
      $display("FAIL thermo_stable: writes=%0d, expected 1", wr_q.size() - n0);
    end
    thermo = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (wr_q.size() - n0 != 2 || wr_q[wr_q.size()-1] !== {8'h01, 16'h0000}) begin
      errors++;
      $display("FAIL thermo_fall: writes=%0d last=%h, expected 2 writes, last 01/0000", wr_q.size() - n0,
               wr_q[wr_q.size()-1]);
    end
  endtask

  task automatic test_force_fan();
    int n0, i;
    n0 = obs_q.size();
    mem[8'h00] = 16'h2000;
    for (i = 0; i < 70 && force_fan !== 1'b1; i++) @(negedge clk);
    checks++;
    if (force_fan !== 1'b1 || obs_q.size() != n0) begin
      errors++;
      $display("FAIL force_fan_on: fan=%b strobes=%0d, expected 1/0", force_fan, obs_q.size() - n0);
    end
    mem[8'h00] = 16'h0000;
    for (i = 0; i < 70 && force_fan !== 1'b0; i++) @(negedge clk);
    checks++;
    if (force_fan !== 1'b0) begin
      errors++;
      $display("FAIL force_fan_off: fan=%b, expected 0", force_fan);
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_atomic();
    checks++;
    if (atomic_bad != 0) begin
      errors++;
      $display("FAIL atomic: %0d settings changes without strobe, expected 0", atomic_bad);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    def_mod = '{req_rd_segment: 1'b0, cycle_0: 16'd0, cycle_1: 16'd0, freq_div_0: 32'd10,
                freq_div_1: 32'd10, rep_0: 16'hFFFF, rep_1: 16'hFFFF, transition_mode: 16'd0};
    def_stm = '{mode: STM_FOCUS, req_rd_segment: 1'b0, cycle_0: 16'd0, cycle_1: 16'd0,
                freq_div_0: 32'd10, freq_div_1: 32'd10, rep_0: 16'hFFFF, rep_1: 16'hFFFF,
                sound_speed_0: 16'd0, sound_speed_1: 16'd0, transition_value: 16'd0};
    def_sil = '{mode: FIXED_COMPLETION_STEPS, update_rate_intensity: 16'd256, update_rate_phase: 16'd256,
                completion_steps_intensity: 16'd10, completion_steps_phase: 16'd40};
    test_reset();
    test_mod_edge();
    test_group_burst("mod_stm_sil", 16'h0007, 0);
    test_group_burst("pwe_dbg_sync", 16'h0038, 3);
    test_reset_mid_load();
    test_thermo();
    test_force_fan();
    test_atomic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctl_reg_fetch.md
Name: ctl_reg_fetch

Overview:
- Sequencer that sits directly downstream of the controller-region BRAM (BRAM_SELECT_CONTROLLER), on its FPGA-side read/write port.
- Polls the control-flag word and detects rising edges on the CTL_FLAG_*_SET bits.
- On each edge, burst-reads that group's register block and commits it atomically to a settings struct with a one-cycle update strobe.
- Writes FPGA_STATE back to the BRAM when the thermo input changes. Feeds the modulation, STM, silencer, pulse-width encoder, debug and sync blocks.

Parameters:
- RD_LATENCY, 2, BRAM read latency in cycles (address in to data valid), legal range 1..3.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous reset, active-low.
- BRAM_ADDR  out  8  controller-BRAM word address.
- BRAM_RD_DATA  in  16  read data, valid RD_LATENCY cycles after BRAM_ADDR.
- BRAM_WE  out  1  write enable.
- BRAM_WR_DATA  out  16  write data.
- THERMO  in  1  thermal-alert input.
- FORCE_FAN  out  1  registered copy of ctl flag bit 13.
- MOD_SETTINGS  out  mod_settings_t  modulation settings.
- STM_SETTINGS  out  stm_settings_t  STM settings.
- SILENCER_SETTINGS  out  silencer_settings_t  silencer settings.
- PWE_FULL_WIDTH_START  out  16  pulse-width encoder full-width start.
- DEBUG_OUT_IDX  out  8  debug output index.
- ECAT_SYNC_TIME  out  64  EtherCAT sync time.
- MOD_UPDATE, STM_UPDATE, SILENCER_UPDATE, PWE_UPDATE, DEBUG_UPDATE, SYNC_UPDATE  out  1 each  one-cycle commit strobes.
- BUSY  out  1  high when not in IDLE.

Behaviour:
- Reset values of all outputs:
  - BRAM_ADDR=0, BRAM_WE=0, BRAM_WR_DATA=0, FORCE_FAN=0, BUSY=0, all strobes 0.
  - Mod: segments 0, cycles 0, freq_div 10, rep 16'hFFFF.
  - STM: mode FOCUS, cycles 0, freq_div 10, rep 16'hFFFF, sound_speed 0.
  - Silencer: mode FIXED_COMPLETION_STEPS, update rates 256, completion steps intensity 10, phase 40.
  - PWE 0, DEBUG 0, sync 0.
  - Internal prev_flag=0 and thermo_last=0.
- FSM states: IDLE, FLAG_RD, DECIDE, LOAD, COMMIT, STATE_WR.
  - IDLE: BRAM_ADDR=ADDR_CTL_FLAG, then go to FLAG_RD.
  - FLAG_RD: wait RD_LATENCY cycles. Capture the flag word, set FORCE_FAN=flag[13], set pending |= flag[5:0] & ~prev_flag[5:0], set prev_flag=flag. Go to DECIDE.
  - DECIDE: if THERMO!=thermo_last, go to STATE_WR. Else if pending!=0, select the lowest set bit (priority mod > stm > silencer > pwe > debug > sync) and go to LOAD. Else go to IDLE.
  - LOAD: issue the group's N consecutive addresses, one per cycle, starting at base. Capture word k into a shadow register RD_LATENCY cycles after issue. Total N+RD_LATENCY cycles.
  - COMMIT (one cycle): copy the shadow into the output struct, pulse the group's UPDATE, clear its pending bit. Go to DECIDE.
  - STATE_WR (one cycle): BRAM_WE=1, BRAM_ADDR=ADDR_FPGA_STATE, BRAM_WR_DATA={15'b0,THERMO}, thermo_last=THERMO. Go to DECIDE.
- Group blocks (base, N):
  - mod: 0x20, 10.
  - stm: 0x50, 14 (STM_MEM_WR_PAGE word is read and discarded).
  - silencer: 0x40, 5.
  - pwe: 0x61, 1.
  - debug: 0xF0, 1 (low byte).
  - sync: 0x11, 4.
- Width rules:
  - 32-bit freq_div = {_1,_0}.
  - 64-bit sync time = {_3,_2,_1,_0}.
  - 1-bit fields (segment, mode) = word bit 0.
- Atomicity: an output struct never changes except in its COMMIT cycle. Partial loads are never visible.
- Edge semantics:
  - A bit held high retriggers nothing.
  - A bit cleared then set during a LOAD is caught at the next FLAG_RD.
  - A bit set-cleared-set faster than one poll loop may be missed; host software guarantees spacing.
- Simultaneous edges: all are queued in pending and serviced in priority order, one COMMIT each, with no strobes overlapping.
- Reset mid-LOAD: outputs return to reset values, the shadow is discarded, pending is cleared.
- Worst-case poll period (all six groups pending plus a state write): about 6·(RD_LATENCY+2)+35+RD_LATENCY+3 cycles.

Decomposition:
- In params:
  - mod_settings_t, stm_settings_t, silencer_settings_t (packed structs).
  - Reset-default constants.
  - Group base/length constants.
  - FSM state enum.
- Sub-module bram_burst_reader: issue N addresses, emit {idx, data, valid} with the RD_LATENCY delay line, plus a done flag.

Test Plan:
- Reset, then flag=0 → all outputs equal defaults (silencer steps 10/40), no strobes, BUSY toggles with the poll loop.
- Write 0x23=0x5678, 0x24=0x0012, then flag bit0 0→1 → exactly one MOD_UPDATE. freq_div_0=0x00125678 in the same cycle. Holding the bit high produces no second strobe.
- Flag 0x0007 set in one write → strobes in order MOD, STM, SILENCER in distinct cycles, never overlapping.
- Assert RST_N=0 in the 5th LOAD cycle of the STM group → STM_SETTINGS stays at defaults, no STM_UPDATE after release until a new edge.
- THERMO 0→1 → one write of 0x0001 to 0x01. 1→0 → one write of 0x0000. No write while stable.
- flag=0x2000 → FORCE_FAN=1 within one poll period, with no update strobes.
